// File: rtl/serial_adder_pkg.sv
// Shared definitions for serial_adder: FSM state encoding and counter sizing helper.
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used by serial_adder for its one-bit-per-cycle datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full adder, WIDTH cycles per operation.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_shift = fa_s;
    end else begin : g_res_many
      assign res_shift = {fa_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        res_d   = res_shift;
        cnt_d   = cnt_q + CW'(1);
        // Publish directly from the final-cycle adder outputs so results update on DONE entry.
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = res_shift;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 (directed + random) and WIDTH=1 (exhaustive).
module tb_serial_adder;

  typedef struct {
    logic [7:0]  sum;
    logic        cout;
    logic        ovf;
    int unsigned due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8, sum8;
  logic [0:0] a1, b1, sum1;
  logic       cin8, cin1;
  logic       busy8, done8, cout8;
  logic       busy1, done1, cout1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  exp_t        q8[$];
  exp_t        q1[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from the signed-range definition.
  function automatic exp_t model(input int unsigned w, input int unsigned a, input int unsigned b,
                                 input int unsigned c, input int unsigned due);
    exp_t r;
    int unsigned tot;
    int sa, sb, ss, lim;
    tot    = a + b + c;
    r.sum  = 8'(tot % (1 << w));
    r.cout = ((tot >> w) & 1) != 0;
    lim    = 1 << (w - 1);
    sa     = (a >= lim) ? int'(a) - (1 << w) : int'(a);
    sb     = (b >= lim) ? int'(b) - (1 << w) : int'(b);
    ss     = sa + sb + int'(c);
    r.ovf  = (ss > lim - 1) || (ss < -lim);
    r.due  = due;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done8: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk("sum8", sum8, e.sum);
        chk("cout8", cout8, e.cout);
        chk("done_cycle8", cyc, e.due);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf8", ovf8, e.ovf);
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done1: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("sum1", {7'd0, sum1}, e.sum);
        chk("cout1", cout1, e.cout);
        chk("done_cycle1", cyc, e.due);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf1", ovf1, e.ovf);
`endif
      end
    end
  end

  // Called just after a negedge; returns at the negedge of the DONE cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit poke);
    logic [7:0] held;
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = c;
    @(posedge clk);
    #1;
    q8.push_back(model(8, a, b, c, cyc + 8));
    held = sum8;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      if (poke && k == 3) begin
        start8 = 1'b1;
        a8     = 8'd1;
        b8     = 8'd1;
        cin8   = 1'b0;
      end
      if (poke && k == 4) start8 = 1'b0;
      chk("busy8_shift", busy8, 1);
      chk("sum8_stable", sum8, held);
    end
    @(negedge clk);
    chk("busy8_done", busy8, 0);
  endtask

  task automatic abort8(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    start8 = 1'b0;
    chk("abort_busy8", busy8, 0);
    chk("abort_done8", done8, 0);
    chk("abort_sum8", sum8, 0);
    chk("abort_cout8", cout8, 0);
    repeat (12) @(negedge clk);
    chk("abort_idle8", busy8, 0);
  endtask

  initial begin
    rst    = 1'b1;
    start8 = 1'b1;
    start1 = 1'b1;
    a8     = 8'hff;
    b8     = 8'hff;
    cin8   = 1'b1;
    a1     = 1'b1;
    b1     = 1'b1;
    cin1   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_sum1", sum1, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf8", ovf8, 0);
`endif
    rst    = 1'b0;
    start8 = 1'b0;
    start1 = 1'b0;
    repeat (2) @(negedge clk);

    op8(8'd3, 8'd5, 1'b0, 1'b0);
    @(negedge clk);
    op8(8'd255, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    op8(8'd0, 8'd0, 1'b1, 1'b0);
    @(negedge clk);
    op8(8'd127, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    op8(8'd255, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    // Mid-operation start ignored, then a back-to-back start in the DONE cycle.
    op8(8'd3, 8'd5, 1'b0, 1'b1);
    op8(8'd10, 8'd20, 1'b1, 1'b0);
    op8(8'd128, 8'd128, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    op8(8'd3, 8'd5, 1'b0, 1'b0);
    @(negedge clk);
    abort8(8'd100, 8'd50);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v      = 3'(i);
      start1 = 1'b1;
      a1     = v[2];
      b1     = v[1];
      cin1   = v[0];
      @(posedge clk);
      #1;
      q1.push_back(model(1, v[2], v[1], v[0], cyc + 1));
      @(negedge clk);
      start1 = 1'b0;
      chk("busy1_shift", busy1, 1);
      @(negedge clk);
      chk("busy1_done", busy1, 0);
      @(negedge clk);
    end

    for (int i = 0; i < 30 && (q8.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("drain_q8", q8.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
